song_sequencer: RTL and testbench

- Parametrised successor to the fixed single-song note library.
- Holds NUM_SONGS songs of up to MAX_LEN notes each, with a per-song length.
- Plays a selected song note by note on a cycle-accurate tempo, with an articulation gap, pause, stop, restart and loop.
- Sits between the user-control logic (buttons/switches) and the tone generator; note code 0 means rest/silence.

---
 rtl/song_sequencer.sv | 139 +++++++++++++
 tb/tb_song_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Multi-song note sequencer: plays notes from a constant ROM on a fixed slot
// tempo with a trailing articulation gap, plus pause, stop, restart and loop.
module song_sequencer #(
  parameter int NUM_SONGS = 4,
  parameter int MAX_LEN   = 32,
  parameter int NOTE_W    = 4,
  parameter int NOTE_CYC  = 25000000,
  parameter int GAP_CYC   = 2500000,
  parameter int LEN_W     = $clog2(MAX_LEN + 1),
  parameter int SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  parameter logic [NUM_SONGS*MAX_LEN*NOTE_W-1:0] SONG_ROM = {
    256'h0,
    128'h0000_0000_0000_0000_0012_2334_4566_5511,
    128'h0000_2334_4552_3344_5512_2334_4566_5511
  },
  parameter logic [NUM_SONGS*LEN_W-1:0] SONG_LENS = {6'd0, 6'd0, 6'd14, 6'd28}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  song_select,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [NOTE_W-1:0] note,
  output logic              note_strobe,
  output logic [LEN_W-1:0]  note_idx,
  output logic              playing,
  output logic              done
);

  localparam int CNT_W   = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
  localparam int SOUND   = NOTE_CYC - GAP_CYC;
  localparam int ROM_AW  = $clog2(NUM_SONGS * MAX_LEN * NOTE_W);
  localparam int LENS_AW = (NUM_SONGS * LEN_W > 1) ? $clog2(NUM_SONGS * LEN_W) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               strobe_d, done_d;
  logic [NOTE_W-1:0]  note_d;
  logic [ROM_AW-1:0]  rom_base;
  logic [LENS_AW-1:0] lens_base;
  logic               slot_end, last_note;

  // The next note is derived from the next index/counter so every output is a flop.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    note_d    = '0;
    lens_base = LENS_AW'(int'(song_select) * LEN_W);
    slot_end  = (cnt_q == CNT_W'(NOTE_CYC - 1));
    last_note = (int'(idx_q) + 1 >= int'(len_q));

    if (stop) begin
      state_d = IDLE;
      sel_d   = '0;
      len_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (start) begin
      sel_d = song_select;
      idx_d = '0;
      cnt_d = '0;
      if (int'(song_select) >= NUM_SONGS) len_d = '0;
      else                                len_d = SONG_LENS[lens_base +: LEN_W];
      if (len_d == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d  = PLAY;
        strobe_d = 1'b1;
      end
    end else begin
      case (state_q)
        PLAY: begin
          state_d = pause ? PAUSE : PLAY;
          if (slot_end) begin
            cnt_d = '0;
            if (!last_note) begin
              idx_d    = idx_q + LEN_W'(1);
              strobe_d = 1'b1;
            end else if (loop_en) begin
              idx_d    = '0;
              strobe_d = 1'b1;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PAUSE: if (!pause) state_d = PLAY;
        default: ;
      endcase
    end

    rom_base = ROM_AW'((int'(sel_d) * MAX_LEN + int'(idx_d)) * NOTE_W);
    if (state_d != IDLE && int'(cnt_d) < SOUND) note_d = SONG_ROM[rom_base +: NOTE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      note        <= '0;
      note_strobe <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      note        <= note_d;
      note_strobe <= strobe_d;
      playing     <= (state_d != IDLE);
      done        <= done_d;
    end
  end

  assign note_idx = idx_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed and random stimulus feed a song-time model;
// a negedge monitor pops the expected outputs and compares them cycle by cycle.
module tb_song_sequencer;
  localparam int NC    = 8;
  localparam int GAP   = 2;
  localparam int LEN_W = 6;

  typedef struct {
    int         cyc;
    logic [3:0] note;
    logic       strobe;
    logic [5:0] idx;
    logic       playing;
    logic       done;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       song_select = '0;
  logic             start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [3:0]       note;
  logic             note_strobe;
  logic [LEN_W-1:0] note_idx;
  logic             playing, done;

  song_sequencer #(.NOTE_CYC(NC), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .song_select(song_select), .start(start),
    .stop(stop), .pause(pause), .loop_en(loop_en), .note(note),
    .note_strobe(note_strobe), .note_idx(note_idx), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   pause_lvl = 1'b0;
  bit   loop_lvl = 1'b0;

  int song0 [28] = '{1,1,5,5,6,6,5,4,4,3,3,2,2,1,5,5,4,4,3,3,2,5,5,4,4,3,3,2};
  int lens [4] = '{28, 14, 0, 0};

  // Model: position is elapsed song time m_t; slot = m_t / NC, offset = m_t % NC.
  bit m_active = 1'b0, m_paused = 1'b0, m_strobe = 1'b0, m_done = 1'b0;
  int m_song = 0, m_len = 0, m_t = 0;

  function automatic int romNote(input int s, input int i);
    if (s == 0 && i < 28) return song0[i];
    if (s == 1 && i < 14) return song0[i];
    return 0;
  endfunction

  task automatic modelReset();
    m_active = 1'b0; m_paused = 1'b0; m_strobe = 1'b0; m_done = 1'b0;
    m_song = 0; m_len = 0; m_t = 0;
  endtask

  task automatic modelStep(input bit st, input bit sp, input bit ps, input bit lp, input int sel);
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (sp) begin
      m_active = 1'b0; m_paused = 1'b0; m_t = 0;
    end else if (st) begin
      m_song = sel; m_len = lens[sel]; m_t = 0; m_paused = 1'b0;
      m_active = (m_len != 0);
      m_strobe = m_active;
      m_done   = !m_active;
    end else if (m_active && !m_paused) begin
      if (m_t % NC == NC - 1 && m_t / NC == m_len - 1) begin
        m_t = 0;
        if (lp) m_strobe = 1'b1;
        else begin m_active = 1'b0; m_done = 1'b1; end
      end else begin
        m_t++;
        m_strobe = (m_t % NC == 0);
      end
      m_paused = m_active && ps;
    end else if (m_active && m_paused) begin
      m_paused = ps;
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input int sel);
    exp_t e;
    @(posedge clk);
    #1;
    start = st; stop = sp; song_select = 2'(sel);
    pause = pause_lvl; loop_en = loop_lvl;
    if (!rst_n) modelReset();
    else        modelStep(st, sp, pause_lvl, loop_lvl, sel);
    e.cyc     = cyc + 1;
    e.playing = m_active;
    e.idx     = m_active ? 6'(m_t / NC) : 6'd0;
    e.note    = (m_active && (m_t % NC) < NC - GAP) ? 4'(romNote(m_song, m_t / NC)) : 4'd0;
    e.strobe  = m_strobe;
    e.done    = m_done;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (note !== e.note || note_strobe !== e.strobe || note_idx !== e.idx ||
        playing !== e.playing || done !== e.done) begin
      errors++;
      $display("[TB] FAIL outputs cyc=%0d got note=%0d strobe=%0b idx=%0d playing=%0b done=%0b, expected note=%0d strobe=%0b idx=%0d playing=%0b done=%0b",
               e.cyc, note, note_strobe, note_idx, playing, done,
               e.note, e.strobe, e.idx, e.playing, e.done);
    end
  endtask

  task automatic checkZero(input string name);
    checks++;
    if (note !== 4'd0 || note_strobe !== 1'b0 || note_idx !== 6'd0 ||
        playing !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s got note=%0d strobe=%0b idx=%0d playing=%0b done=%0b, expected all zero",
               name, note, note_strobe, note_idx, playing, done);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 checkZero("reset state");
    idle(2);
    #1 rst_n = 1'b1;
    idle(3);

    $display("[TB] song 0 full play");
    applyStimulus(1'b1, 1'b0, 0);
    idle(28 * NC + 10);

    $display("[TB] song 1 looped, then loop cleared");
    loop_lvl = 1'b1;
    applyStimulus(1'b1, 1'b0, 1);
    idle(40 * NC);
    loop_lvl = 1'b0;
    idle(14 * NC + 10);

    $display("[TB] pause at note 2 offset 3");
    applyStimulus(1'b1, 1'b0, 0);
    idle(19);
    pause_lvl = 1'b1;
    idle(20);
    pause_lvl = 1'b0;
    idle(30);

    $display("[TB] empty song");
    applyStimulus(1'b1, 1'b0, 2);
    idle(3);

    $display("[TB] stop, restart, start with stop");
    applyStimulus(1'b1, 1'b0, 0);
    idle(10 * NC + 3);
    applyStimulus(1'b0, 1'b1, 0);
    idle(3);
    applyStimulus(1'b1, 1'b0, 0);
    idle(5 * NC + 2);
    applyStimulus(1'b1, 1'b0, 1);
    idle(20);
    applyStimulus(1'b1, 1'b1, 0);
    idle(3);

    $display("[TB] start while pause held");
    pause_lvl = 1'b1;
    applyStimulus(1'b1, 1'b0, 0);
    idle(5);
    pause_lvl = 1'b0;
    idle(10);

    $display("[TB] async reset mid-note");
    applyStimulus(1'b1, 1'b0, 0);
    idle(37);
    #2 rst_n = 1'b0;
    #1 checkZero("async reset");
    sb.delete();
    modelReset();
    idle(3);
    #1 rst_n = 1'b1;
    pause_lvl = 1'b1;
    idle(10);
    pause_lvl = 1'b0;
    applyStimulus(1'b1, 1'b0, 1);
    idle(20);

    $display("[TB] random stimulus");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) pause_lvl = !pause_lvl;
      if ($urandom_range(0, 49) == 0) loop_lvl = !loop_lvl;
      applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0,
                    int'($urandom_range(0, 3)));
    end
    pause_lvl = 1'b0;
    idle(4);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
